// File: rtl/uart_tx_mmio_if.sv
// Load/store port between the SoC core and the UART transmitter peripheral.
// The core drives address, store type/data and the load strobe; the peripheral returns data_out.
interface uart_tx_mmio_if;
    logic [31:0] address;
    logic [1:0]  write_type;
    logic [31:0] data_in;
    logic        read_en;
    logic [31:0] data_out;

    modport master (
        output address,
        output write_type,
        output data_in,
        output read_en,
        input  data_out
    );

    modport slave (
        input  address,
        input  write_type,
        input  data_in,
        input  read_en,
        output data_out
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to ADDR_DATA queue bytes in a small FIFO,
// loads return status or FIFO occupancy one cycle later, and a serializer drains the FIFO.
module uart_tx_mmio #(
    parameter int          CLK_FREQ        = 27_000_000,
    parameter int          BAUD_RATE       = 115200,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [31:0] ADDR_DATA       = 32'hFFFF_FFFC,
    parameter logic [31:0] ADDR_STATUS     = 32'hFFFF_FFF8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus,
    output logic          tx,
    output logic          busy
);
    // CLKS_PER_BIT must be at least 2 so the baud counter has a nonzero width.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = FIFO_DEPTH_LOG2;
    localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic             ovf_set;
    logic             status_rd;
    logic             overflow;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             tx_n;
    logic             unused_data_hi;

    assign unused_data_hi = ^bus.data_in[31:8];

    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = (bus.write_type != 2'd0) && (bus.address == ADDR_DATA);
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok   = push && (!full || pop);
    assign ovf_set   = push && full && !pop;
    assign status_rd = bus.read_en && (bus.address == ADDR_STATUS);
    assign busy      = !empty || (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = mem[rd_ptr];
                    state_n = START;
                    tx_n    = 1'b0;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == CNT_LAST) begin
                    state_n   = DATA;
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                    tx_n      = shreg[0];
                    shreg_n   = {1'b1, shreg[7:1]};
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shreg[0];
                        shreg_n   = {1'b1, shreg[7:1]};
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    // Back-to-back frames: go straight to the next start bit.
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = mem[rd_ptr];
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Load results and the sticky overflow flag use pre-edge state; a new overflow beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow     <= 1'b0;
            bus.data_out <= 32'd0;
        end else begin
            overflow <= ovf_set | (overflow & ~status_rd);
            if (bus.read_en) begin
                if (status_rd) begin
                    bus.data_out <= {28'd0, overflow, (state != IDLE), empty, full};
                end else if (bus.address == ADDR_DATA) begin
                    bus.data_out <= 32'(count);
                end else begin
                    bus.data_out <= 32'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a queue-and-frame-time model checked every cycle,
// directed scenarios with literal expectations, then a randomized load/store phase.
module tb_uart_tx_mmio;
    localparam int          CLK_FREQ    = 100;
    localparam int          BAUD_RATE   = 10;
    localparam int          CPB         = 10;
    localparam int          DEPTH       = 8;
    localparam logic [31:0] ADDR_DATA   = 32'hFFFF_FFFC;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD_RATE      (BAUD_RATE),
        .FIFO_DEPTH_LOG2(3),
        .ADDR_DATA      (ADDR_DATA),
        .ADDR_STATUS    (ADDR_STATUS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Model: queued bytes, plus the byte on the line and how many edges since its start bit began.
    logic [7:0]  q[$];
    logic        m_act = 1'b0;
    logic        m_ovf = 1'b0;
    logic [7:0]  m_cur = 8'd0;
    int          m_t = 0;
    logic [31:0] m_dout = 32'd0;
    bit          model_ok = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int t);
        int k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        int   n0;
        logic full0, act0, ovf0, popn, pushn, strd, oset;
        if (rst) begin
            q.delete();
            m_act    = 1'b0;
            m_ovf    = 1'b0;
            m_t      = 0;
            m_dout   = 32'd0;
            model_ok = 1'b1;
        end else begin
            n0    = q.size();
            full0 = (n0 == DEPTH);
            act0  = m_act;
            ovf0  = m_ovf;
            pushn = (bus.write_type != 2'd0) && (bus.address == ADDR_DATA);
            strd  = bus.read_en && (bus.address == ADDR_STATUS);
            if (bus.read_en) begin
                if (strd) m_dout = {28'd0, ovf0, act0, (n0 == 0), full0};
                else if (bus.address == ADDR_DATA) m_dout = 32'(n0);
                else m_dout = 32'd0;
            end
            popn = 1'b0;
            if (m_act) begin
                m_t++;
                if (m_t == 10 * CPB) begin
                    if (n0 > 0) popn = 1'b1;
                    else m_act = 1'b0;
                end
            end else if (n0 > 0) begin
                popn = 1'b1;
            end
            if (popn) begin
                m_cur = q.pop_front();
                m_act = 1'b1;
                m_t   = 0;
            end
            oset = pushn && full0 && !popn;
            if (pushn && !oset) q.push_back(bus.data_in[7:0]);
            m_ovf = oset ? 1'b1 : (strd ? 1'b0 : ovf0);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("tx", 32'(tx), 32'(m_act ? frame_bit(m_cur, m_t) : 1'b1));
            check("busy", 32'(busy), 32'((q.size() != 0) || m_act));
            check("data_out", bus.data_out, m_dout);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] wt, input logic [31:0] d, input logic rd);
        bus.address    = a;
        bus.write_type = wt;
        bus.data_in    = d;
        bus.read_en    = rd;
    endtask

    task automatic idle_bus();
        drive(32'd0, 2'd0, 32'd0, 1'b0);
    endtask

    logic [9:0] pat;
    logic [1:0] wt;
    logic [31:0] addr;

    initial begin
        rst = 1'b1;
        idle_bus();
        step(2);
        rst = 1'b0;

        // Reset state and first status read
        drive(ADDR_STATUS, 2'd0, 32'd0, 1'b1);
        step(1);
        idle_bus();
        check("t1_status", bus.data_out, 32'h0000_0002);
        check("t1_tx", 32'(tx), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);

        // Single sb 0x55
        drive(ADDR_DATA, 2'd1, 32'h0000_0055, 1'b0);
        step(1);
        idle_bus();
        step(1);
        check("t2_fall", 32'(tx), 32'd0);
        pat = 10'h2AA;
        step(5);
        for (int k = 0; k < 10; k++) begin
            check("t2_bit", 32'(tx), 32'(pat[k]));
            if (k < 9) step(10);
        end
        step(4);
        check("t2_busy_hi", 32'(busy), 32'd1);
        step(1);
        check("t2_busy_lo", 32'(busy), 32'd0);

        // sw: only the low byte is sent; count reads 1 before the pop
        drive(ADDR_DATA, 2'd3, 32'h1234_56A5, 1'b0);
        step(1);
        drive(ADDR_DATA, 2'd0, 32'd0, 1'b1);
        step(1);
        idle_bus();
        check("t3_count", bus.data_out, 32'd1);
        check("t3_fall", 32'(tx), 32'd0);
        pat = 10'h34A;
        step(5);
        for (int k = 0; k < 10; k++) begin
            check("t3_bit", 32'(tx), 32'(pat[k]));
            if (k < 9) step(10);
        end
        step(10);

        // Ten pushes on consecutive edges: nine kept, tenth overflows
        for (int i = 0; i < 10; i++) begin
            drive(ADDR_DATA, 2'd1, 32'($urandom_range(0, 255)), 1'b0);
            step(1);
        end
        drive(ADDR_STATUS, 2'd0, 32'd0, 1'b1);
        step(1);
        check("t4_status_ovf", bus.data_out, 32'h0000_000D);
        step(1);
        idle_bus();
        check("t4_status_clr", bus.data_out, 32'h0000_0005);
        step(889);
        check("t4_busy_hi", 32'(busy), 32'd1);
        step(1);
        check("t4_busy_lo", 32'(busy), 32'd0);

        // Back-to-back frames 0x00 then 0xFF
        drive(ADDR_DATA, 2'd1, 32'h0000_0000, 1'b0);
        step(1);
        drive(ADDR_DATA, 2'd1, 32'h0000_00FF, 1'b0);
        step(1);
        idle_bus();
        check("t5_fall", 32'(tx), 32'd0);
        step(99);
        check("t5_stop", 32'(tx), 32'd1);
        step(1);
        check("t5_start2", 32'(tx), 32'd0);
        step(50);
        check("t5_data2", 32'(tx), 32'd1);
        step(49);
        check("t5_busy_hi", 32'(busy), 32'd1);
        step(1);
        check("t5_busy_lo", 32'(busy), 32'd0);
        check("t5_idle_tx", 32'(tx), 32'd1);

        // Reset mid-frame with three bytes queued
        for (int i = 0; i < 4; i++) begin
            drive(ADDR_DATA, 2'd1, 32'h0000_0000, 1'b0);
            step(1);
        end
        idle_bus();
        step(32);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_tx", 32'(tx), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        drive(ADDR_DATA, 2'd0, 32'd0, 1'b1);
        step(1);
        idle_bus();
        check("t6_count", bus.data_out, 32'd0);
        step(200);
        check("t6_quiet_tx", 32'(tx), 32'd1);
        check("t6_quiet_busy", 32'(busy), 32'd0);

        // Randomized loads and stores, alternating light and heavy store traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50) addr = ADDR_DATA;
            else if (r < 80) addr = ADDR_STATUS;
            else addr = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
            if (((c / 500) % 2) == 1) wt = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
            else wt = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
            drive(addr, wt, $urandom, ($urandom_range(0, 9) < 3));
            rst = ($urandom_range(0, 1499) == 0);
            step(1);
        end
        rst = 1'b0;
        idle_bus();
        step(1000);
        check("end_busy", 32'(busy), 32'd0);
        check("end_tx", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
